// File: rtl/registers_bank_pkg.sv
// Shared defaults and types for the multi-port register bank.
package registers_bank_pkg;
  localparam int unsigned REG_DATA_W = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned ZERO_ADDR  = 0;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_DATA_W-1:0] reg_data_t;
endpackage

// File: rtl/registers_bank_mp_if.sv
// Bundles the read, write and reservation buses of the register bank.
interface registers_bank_mp_if
  import registers_bank_pkg::*;
#(
  parameter int unsigned DATA_W = REG_DATA_W,
  parameter int unsigned ADDR_W = REG_ADDR_W,
  parameter int unsigned NUM_RD = 2,
  parameter int unsigned NUM_WR = 2
) ();
  logic [NUM_RD*ADDR_W-1:0] read_register;
  logic [NUM_RD*DATA_W-1:0] read_data;
  logic [NUM_RD-1:0]        read_busy;
  logic [NUM_WR-1:0]        write_enable;
  logic [NUM_WR*ADDR_W-1:0] write_register;
  logic [NUM_WR*DATA_W-1:0] write_data;
  logic                     reserve_valid;
  logic [ADDR_W-1:0]        reserve_register;
  logic [ADDR_W:0]          busy_count;

  modport master (
    output read_register, write_enable, write_register, write_data,
           reserve_valid, reserve_register,
    input  read_data, read_busy, busy_count
  );

  modport slave (
    input  read_register, write_enable, write_register, write_data,
           reserve_valid, reserve_register,
    output read_data, read_busy, busy_count
  );
endinterface

// File: rtl/registers_scoreboard.sv
// Per-register busy bits with reserve/clear priority and a registered popcount.
module registers_scoreboard
  import registers_bank_pkg::*;
#(
  parameter int unsigned ADDR_W   = REG_ADDR_W,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned NUM_WR   = 2,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic [NUM_RD*ADDR_W-1:0] i_read_register,
  input  logic [NUM_WR-1:0]        i_write_enable,
  input  logic [NUM_WR*ADDR_W-1:0] i_write_register,
  input  logic                     i_reserve_valid,
  input  logic [ADDR_W-1:0]        i_reserve_register,
  output logic [NUM_RD-1:0]        o_read_busy,
  output logic [ADDR_W:0]          o_busy_count
);
  localparam int unsigned       DEPTH  = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_ADDR);

  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] w_busy_next;
  logic [ADDR_W:0]  r_count;
  logic [ADDR_W:0]  w_count_next;

  // Clears first so a same-cycle reservation (newer producer) wins.
  always_comb begin
    w_busy_next = r_busy;
    for (int unsigned j = 0; j < NUM_WR; j++) begin
      if (i_write_enable[j]) begin
        w_busy_next[i_write_register[j*ADDR_W +: ADDR_W]] = 1'b0;
      end
    end
    if (i_reserve_valid && !(ZERO_REG && i_reserve_register == ZERO_A)) begin
      w_busy_next[i_reserve_register] = 1'b1;
    end
    w_count_next = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_count_next = w_count_next + (ADDR_W+1)'(w_busy_next[i]);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_busy  <= '0;
      r_count <= '0;
    end else begin
      r_busy  <= w_busy_next;
      r_count <= w_count_next;
    end
  end

  always_comb begin : p_read_busy
    logic [ADDR_W-1:0] ra;
    logic              hit;
    ra          = '0;
    hit         = 1'b0;
    o_read_busy = '0;
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      ra  = i_read_register[k*ADDR_W +: ADDR_W];
      hit = 1'b0;
      for (int unsigned j = 0; j < NUM_WR; j++) begin
        if (i_write_enable[j] && i_write_register[j*ADDR_W +: ADDR_W] == ra) begin
          hit = 1'b1;
        end
      end
      o_read_busy[k] = r_busy[ra] && !hit;
    end
  end

  assign o_busy_count = r_count;
endmodule

// File: rtl/registers_bank_mp.sv
// Multi-port register file with write-to-read bypass and an issue scoreboard.
module registers_bank_mp
  import registers_bank_pkg::*;
#(
  parameter int unsigned DATA_W   = REG_DATA_W,
  parameter int unsigned ADDR_W   = REG_ADDR_W,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned NUM_WR   = 2,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic [NUM_RD*ADDR_W-1:0] i_read_register,
  output logic [NUM_RD*DATA_W-1:0] o_read_data,
  output logic [NUM_RD-1:0]        o_read_busy,
  input  logic [NUM_WR-1:0]        i_write_enable,
  input  logic [NUM_WR*ADDR_W-1:0] i_write_register,
  input  logic [NUM_WR*DATA_W-1:0] i_write_data,
  input  logic                     i_reserve_valid,
  input  logic [ADDR_W-1:0]        i_reserve_register,
  output logic [ADDR_W:0]          o_busy_count
);
  localparam int unsigned       DEPTH  = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_ADDR);

  generate
    if (NUM_RD < 1 || NUM_WR < 1 || ADDR_W < 1) begin : g_bad_params
      $error("registers_bank_mp: NUM_RD, NUM_WR and ADDR_W must all be >= 1");
    end
  endgenerate

  logic [DATA_W-1:0] r_regs [DEPTH];

  // Ascending port order: the last NBA to an address (highest port) wins.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      for (int unsigned j = 0; j < NUM_WR; j++) begin
        if (i_write_enable[j] &&
            !(ZERO_REG && i_write_register[j*ADDR_W +: ADDR_W] == ZERO_A)) begin
          r_regs[i_write_register[j*ADDR_W +: ADDR_W]] <= i_write_data[j*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_comb begin : p_read
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;
    ra          = '0;
    rd          = '0;
    o_read_data = '0;
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      ra = i_read_register[k*ADDR_W +: ADDR_W];
      rd = r_regs[ra];
      for (int unsigned j = 0; j < NUM_WR; j++) begin
        if (i_write_enable[j] && i_write_register[j*ADDR_W +: ADDR_W] == ra) begin
          rd = i_write_data[j*DATA_W +: DATA_W];
        end
      end
      if (ZERO_REG && ra == ZERO_A) begin
        rd = '0;
      end
      o_read_data[k*DATA_W +: DATA_W] = rd;
    end
  end

  registers_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NUM_RD   (NUM_RD),
    .NUM_WR   (NUM_WR),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .i_clk              (i_clk),
    .i_reset            (i_reset),
    .i_read_register    (i_read_register),
    .i_write_enable     (i_write_enable),
    .i_write_register   (i_write_register),
    .i_reserve_valid    (i_reserve_valid),
    .i_reserve_register (i_reserve_register),
    .o_read_busy        (o_read_busy),
    .o_busy_count       (o_busy_count)
  );
endmodule

// File: tb/tb_registers_bank_mp.sv
// Randomized and directed stimulus against a behavioural model, checked via a queue.
module tb_registers_bank_mp;
  import registers_bank_pkg::*;

  localparam int NR    = 2;
  localparam int NW    = 2;
  localparam int AW    = REG_ADDR_W;
  localparam int DW    = REG_DATA_W;
  localparam int DEPTH = 1 << AW;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  registers_bank_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW)) bus ();

  registers_bank_mp #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW), .ZERO_REG(1'b1)
  ) dut (
    .i_clk              (clk),
    .i_reset            (rst_n),
    .i_read_register    (bus.read_register),
    .o_read_data        (bus.read_data),
    .o_read_busy        (bus.read_busy),
    .i_write_enable     (bus.write_enable),
    .i_write_register   (bus.write_register),
    .i_write_data       (bus.write_data),
    .i_reserve_valid    (bus.reserve_valid),
    .i_reserve_register (bus.reserve_register),
    .o_busy_count       (bus.busy_count)
  );

  typedef struct packed {
    logic [NR*DW-1:0] rdata;
    logic [NR-1:0]    rbusy;
    logic [AW:0]      cnt;
  } exp_t;

  exp_t      exp_q[$];
  reg_data_t m_mem  [DEPTH];
  bit        m_busy [DEPTH];
  int        checks   = 0;
  int        failures = 0;

  function automatic int wr_addr(int j);
    return int'(bus.write_register[j*AW +: AW]);
  endfunction

  function automatic bit wr_hit(int a);
    for (int j = 0; j < NW; j++)
      if (bus.write_enable[j] && wr_addr(j) == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic reg_data_t exp_read(int a);
    if (a == 0) return '0;
    for (int j = NW - 1; j >= 0; j--)
      if (bus.write_enable[j] && wr_addr(j) == a) return bus.write_data[j*DW +: DW];
    return m_mem[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  // Predict this cycle's outputs, clock once, then apply the edge to the model.
  task automatic cycle();
    exp_t e;
    int   c;
    int   a;
    e = '0;
    c = 0;
    for (int k = 0; k < NR; k++) begin
      a = int'(bus.read_register[k*AW +: AW]);
      e.rdata[k*DW +: DW] = exp_read(a);
      e.rbusy[k] = (a != 0) && m_busy[a] && !wr_hit(a);
    end
    for (int i = 0; i < DEPTH; i++) c += int'(m_busy[i]);
    e.cnt = (AW+1)'(c);
    exp_q.push_back(e);
    @(posedge clk);
    if (!rst_n) begin
      model_clear();
    end else begin
      for (int j = 0; j < NW; j++) begin
        if (bus.write_enable[j]) begin
          if (wr_addr(j) != 0) m_mem[wr_addr(j)] = bus.write_data[j*DW +: DW];
          m_busy[wr_addr(j)] = 1'b0;
        end
      end
      if (bus.reserve_valid && bus.reserve_register != '0)
        m_busy[int'(bus.reserve_register)] = 1'b1;
    end
    #1;
  endtask

  task automatic idle();
    bus.read_register    = '0;
    bus.write_enable     = '0;
    bus.write_register   = '0;
    bus.write_data       = '0;
    bus.reserve_valid    = 1'b0;
    bus.reserve_register = '0;
  endtask

  task automatic set_rd(int k, int a);
    bus.read_register[k*AW +: AW] = AW'(a);
  endtask

  task automatic set_wr(int j, int a, logic [DW-1:0] d);
    bus.write_enable[j]            = 1'b1;
    bus.write_register[j*AW +: AW] = AW'(a);
    bus.write_data[j*DW +: DW]     = d;
  endtask

  task automatic reserve(int a);
    bus.reserve_valid    = 1'b1;
    bus.reserve_register = AW'(a);
  endtask

  function automatic int rand_addr();
    return ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, DEPTH - 1));
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        for (int k = 0; k < NR; k++) begin
          checks++;
          if (bus.read_data[k*DW +: DW] !== e.rdata[k*DW +: DW]) begin
            failures++;
            $display("FAIL rdata[%0d] @%0t actual=%h required=%h", k, $time,
                     bus.read_data[k*DW +: DW], e.rdata[k*DW +: DW]);
          end
          checks++;
          if (bus.read_busy[k] !== e.rbusy[k]) begin
            failures++;
            $display("FAIL rbusy[%0d] @%0t actual=%b required=%b", k, $time,
                     bus.read_busy[k], e.rbusy[k]);
          end
        end
        checks++;
        if (bus.busy_count !== e.cnt) begin
          failures++;
          $display("FAIL busy_count @%0t actual=%0d required=%0d", $time, bus.busy_count, e.cnt);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    idle();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    model_clear();
    rst_n = 1'b1;

    // Reset state
    idle(); set_rd(0, 9); set_rd(1, 31); cycle();

    // Dual write then read back
    idle(); set_wr(0, 1, 32'h11111111); set_wr(1, 2, 32'h22222222); cycle();
    idle(); set_rd(0, 1); set_rd(1, 2); cycle();

    // Same-address write collision with bypass
    idle(); set_wr(0, 5, 32'hAAAAAAAA); set_wr(1, 5, 32'hBBBBBBBB); set_rd(0, 5); cycle();
    idle(); set_rd(0, 5); set_rd(1, 5); cycle();

    // Register zero
    idle(); set_wr(0, 0, 32'hDEADBEEF); set_rd(0, 0); cycle();
    idle(); set_rd(0, 0); reserve(0); cycle();
    idle(); set_rd(1, 0); cycle();

    // Reservation lifecycle on reg 7
    idle(); reserve(7); cycle();
    idle(); set_rd(0, 7); cycle();
    idle(); set_wr(0, 7, 32'h77); reserve(7); set_rd(0, 7); cycle();
    idle(); set_rd(0, 7); cycle();
    idle(); reserve(7); cycle();
    idle(); set_wr(1, 7, 32'h78); set_rd(1, 7); cycle();
    idle(); set_rd(0, 7); set_rd(1, 7); cycle();

    // Reset mid-operation, then write on the deassertion cycle
    idle(); reserve(3); cycle();
    idle(); reserve(4); set_wr(0, 3, 32'h33); cycle();
    idle(); set_rd(0, 3); set_rd(1, 4); rst_n = 1'b0; cycle();
    rst_n = 1'b1;
    idle(); set_wr(0, 4, 32'h44); set_rd(0, 3); set_rd(1, 4); cycle();
    idle(); set_rd(0, 4); set_rd(1, 3); cycle();

    // Randomized traffic
    for (int n = 0; n < 10000; n++) begin
      idle();
      rst_n = ($urandom_range(0, 299) != 0);
      for (int k = 0; k < NR; k++) set_rd(k, rand_addr());
      for (int j = 0; j < NW; j++)
        if ($urandom_range(0, 1) == 1) set_wr(j, rand_addr(), DW'($urandom));
      if ($urandom_range(0, 1) == 1) reserve(rand_addr());
      cycle();
    end
    rst_n = 1'b1;
    idle();

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain: actual=%0d pending required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
